// File: rtl/fifo_multi_pop_pkg.sv
// Shared constants, pointer type and helpers for the 4-bank multi-pop FIFO.
// Pointer index field is sized for the largest supported depth.
package fifo_multi_pop_pkg;

   localparam int NB      = 4;
   localparam int NB_LOG2 = 2;
   localparam int IDX_W   = 16;

   typedef struct packed {
      logic             wrap;
      logic [IDX_W-1:0] idx;
   } ptr_t;

   function automatic logic [NB_LOG2-1:0] oh2bin(input logic [NB-1:0] oh);
      logic [NB_LOG2-1:0] b;
      b = '0;
      for (int i = 0; i < NB; i++) begin
         if (oh[i]) b = b | NB_LOG2'(i);
      end
      return b;
   endfunction

   function automatic logic [NB_LOG2:0] popcnt(input logic [NB-1:0] v);
      logic [NB_LOG2:0] c;
      c = '0;
      for (int i = 0; i < NB; i++) begin
         c = c + {{NB_LOG2{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Wrap bit toggles each time the index passes the last slot.
   function automatic ptr_t ptr_inc(input ptr_t p,
                                    input logic [IDX_W-1:0] last);
      ptr_t r;
      r = p;
      if (p.idx == last) begin
         r.idx  = '0;
         r.wrap = ~p.wrap;
      end else begin
         r.idx = p.idx + IDX_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_multi_pop_rotate.sv
// One-hot left rotation by 0..NB positions (NB is identity).
module fifo_multi_pop_rotate
   import fifo_multi_pop_pkg::*;
(
   input  logic [NB-1:0]    in_oh,
   input  logic [NB_LOG2:0] amt,
   output logic [NB-1:0]    out_oh
);

   logic [2*NB-1:0] dbl;

   always_comb begin
      dbl    = {in_oh, in_oh} << amt;
      out_oh = dbl[2*NB-1:NB];
   end

endmodule

// File: rtl/fifo_multi_pop.sv
// Four-bank round-robin FIFO: one push and up to four in-order pops per cycle.
// Define FIFO_MULTI_POP_CNT_EN to add the registered occupancy output cnt_r.
module fifo_multi_pop
   import fifo_multi_pop_pkg::*;
#(
   parameter int W = 32,
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_0,
   input  logic         pop_1,
   input  logic         pop_2,
   input  logic         pop_3,
   output logic         pop_0_valid_r,
   output logic         pop_1_valid_r,
   output logic         pop_2_valid_r,
   output logic         pop_3_valid_r,
   output logic [W-1:0] pop_0_data_r,
   output logic [W-1:0] pop_1_data_r,
   output logic [W-1:0] pop_2_data_r,
   output logic [W-1:0] pop_3_data_r,
`ifdef FIFO_MULTI_POP_CNT_EN
   output logic [$clog2(4*N):0] cnt_r,
`endif
   output logic         full_r,
   output logic [3:0]   empty_r
);

   localparam int AW = $clog2(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

   logic [W-1:0] mem_q [NB][N];

   ptr_t wp_q [NB];
   ptr_t wp_d [NB];
   ptr_t rp_q [NB];
   ptr_t rp_d [NB];

   logic [NB-1:0] push_idx_q, push_idx_d;
   logic [NB-1:0] pop_idx_q, pop_idx_d;
   logic          full_q, full_d;
   logic [NB-1:0] empty_q, empty_d;
   logic [NB-1:0] valid_q, valid_d;
   logic [W-1:0]  data_q [NB];
   logic [W-1:0]  data_d [NB];

   logic [NB-1:0]      pop_req, pop_acc;
   logic               push_acc;
   logic [NB_LOG2:0]   pop_n;
   logic [NB_LOG2-1:0] wr_bank, rd_base, nx_base, nx_wr;
   logic [NB_LOG2-1:0] slot_bank [NB];
   logic [NB_LOG2-1:0] nx_bank [NB];

   assign pop_req  = {pop_3, pop_2, pop_1, pop_0};
   assign push_acc = push & ~full_q;
   assign pop_n    = popcnt(pop_acc);

   // Pops are honoured only as a contiguous prefix starting at slot 0.
   always_comb begin
      logic ok;
      ok      = 1'b1;
      pop_acc = '0;
      for (int k = 0; k < NB; k++) begin
         ok         = ok & pop_req[k] & ~empty_q[k];
         pop_acc[k] = ok;
      end
   end

   fifo_multi_pop_rotate u_push_rot (
      .in_oh  (push_idx_q),
      .amt    ({{NB_LOG2{1'b0}}, push_acc}),
      .out_oh (push_idx_d)
   );

   fifo_multi_pop_rotate u_pop_rot (
      .in_oh  (pop_idx_q),
      .amt    (pop_n),
      .out_oh (pop_idx_d)
   );

   always_comb begin
      wr_bank = oh2bin(push_idx_q);
      rd_base = oh2bin(pop_idx_q);
      nx_base = oh2bin(pop_idx_d);
      nx_wr   = oh2bin(push_idx_d);
      for (int k = 0; k < NB; k++) begin
         slot_bank[k] = rd_base + NB_LOG2'(k);
         nx_bank[k]   = nx_base + NB_LOG2'(k);
      end
   end

   always_comb begin
      for (int b = 0; b < NB; b++) begin
         wp_d[b] = wp_q[b];
         rp_d[b] = rp_q[b];
      end
      if (push_acc) begin
         wp_d[wr_bank] = ptr_inc(wp_q[wr_bank], LAST);
      end
      for (int k = 0; k < NB; k++) begin
         data_d[k] = mem_q[slot_bank[k]][rp_q[slot_bank[k]].idx[AW-1:0]];
         if (pop_acc[k]) begin
            rp_d[slot_bank[k]] = ptr_inc(rp_q[slot_bank[k]], LAST);
         end
      end
      valid_d = pop_acc;
      // Slot k is non-empty iff its bank is; the next write bank is full only at 4N.
      for (int k = 0; k < NB; k++) begin
         empty_d[k] = (wp_d[nx_bank[k]] == rp_d[nx_bank[k]]);
      end
      full_d = (wp_d[nx_wr].wrap != rp_d[nx_wr].wrap) &&
               (wp_d[nx_wr].idx == rp_d[nx_wr].idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NB; b++) begin
            wp_q[b] <= '0;
            rp_q[b] <= '0;
         end
         push_idx_q <= NB'(1);
         pop_idx_q  <= NB'(1);
         full_q     <= 1'b0;
         empty_q    <= '1;
         valid_q    <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            wp_q[b] <= wp_d[b];
            rp_q[b] <= rp_d[b];
         end
         push_idx_q <= push_idx_d;
         pop_idx_q  <= pop_idx_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_bank][wp_q[wr_bank].idx[AW-1:0]] <= push_data;
      end
      for (int k = 0; k < NB; k++) begin
         data_q[k] <= data_d[k];
      end
   end

`ifdef FIFO_MULTI_POP_CNT_EN
   localparam int CW = $clog2(4*N) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(push_acc) - CW'(pop_n);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_r = cnt_q;
`endif

   assign pop_0_valid_r = valid_q[0];
   assign pop_1_valid_r = valid_q[1];
   assign pop_2_valid_r = valid_q[2];
   assign pop_3_valid_r = valid_q[3];
   assign pop_0_data_r  = data_q[0];
   assign pop_1_data_r  = data_q[1];
   assign pop_2_data_r  = data_q[2];
   assign pop_3_data_r  = data_q[3];
   assign full_r        = full_q;
   assign empty_r       = empty_q;

endmodule

// File: tb/tb_fifo_multi_pop.sv
// Directed bench for fifo_multi_pop (W=32, N=8, default build).
module tb_fifo_multi_pop;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [31:0] push_data;
   logic        pop_0, pop_1, pop_2, pop_3;
   logic        v0, v1, v2, v3;
   logic [31:0] d0, d1, d2, d3;
   logic        full_r;
   logic [3:0]  empty_r;

   int checks   = 0;
   int failures = 0;

   fifo_multi_pop #(.W(32), .N(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .push          (push),
      .push_data     (push_data),
      .pop_0         (pop_0),
      .pop_1         (pop_1),
      .pop_2         (pop_2),
      .pop_3         (pop_3),
      .pop_0_valid_r (v0),
      .pop_1_valid_r (v1),
      .pop_2_valid_r (v2),
      .pop_3_valid_r (v3),
      .pop_0_data_r  (d0),
      .pop_1_data_r  (d1),
      .pop_2_data_r  (d2),
      .pop_3_data_r  (d3),
      .full_r        (full_r),
      .empty_r       (empty_r)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pops(input logic [3:0] m);
      {pop_3, pop_2, pop_1, pop_0} = m;
   endtask

   task automatic push_one(input logic [31:0] d);
      push      = 1'b1;
      push_data = d;
      tick();
      push      = 1'b0;
   endtask

   task automatic pop_cycle(input string tag, input logic [3:0] req,
                            input logic [3:0] ev, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3);
      set_pops(req);
      tick();
      set_pops(4'b0000);
      check({tag, "_valid"}, {60'd0, v3, v2, v1, v0}, {60'd0, ev});
      if (ev[0]) check({tag, "_d0"}, {32'd0, d0}, {32'd0, e0});
      if (ev[1]) check({tag, "_d1"}, {32'd0, d1}, {32'd0, e1});
      if (ev[2]) check({tag, "_d2"}, {32'd0, d2}, {32'd0, e2});
      if (ev[3]) check({tag, "_d3"}, {32'd0, d3}, {32'd0, e3});
   endtask

   task automatic check_flags(input string tag, input logic ef,
                              input logic [3:0] ee);
      check({tag, "_full"}, {63'd0, full_r}, {63'd0, ef});
      check({tag, "_empty"}, {60'd0, empty_r}, {60'd0, ee});
   endtask

   initial begin
      rst = 1'b1;
      push = 1'b0;
      push_data = '0;
      set_pops(4'b0000);
      tick();
      tick();
      rst = 1'b0;
      check_flags("reset", 1'b0, 4'b1111);
      check("reset_valid", {60'd0, v3, v2, v1, v0}, 64'd0);

      // Four pushes, then all four popped together
      for (int i = 0; i < 4; i++) push_one(32'h10 + i);
      check_flags("p4", 1'b0, 4'b0000);
      pop_cycle("pop4", 4'b1111, 4'b1111, 32'h10, 32'h11, 32'h12, 32'h13);
      check_flags("pop4", 1'b0, 4'b1111);

      // Fill to 32, drop the 33rd, drain four per cycle
      for (int i = 0; i < 32; i++) begin
         push_one(32'h100 + i);
         if (i == 30) check("fill31_full", {63'd0, full_r}, 64'd0);
      end
      check_flags("fill32", 1'b1, 4'b0000);
      push_one(32'hDEAD);
      check("drop33_full", {63'd0, full_r}, 64'd1);
      for (int c = 0; c < 8; c++) begin
         pop_cycle("drain", 4'b1111, 4'b1111, 32'h100 + 4*c,
                   32'h101 + 4*c, 32'h102 + 4*c, 32'h103 + 4*c);
         check("drain_full", {63'd0, full_r}, 64'd0);
      end
      check_flags("drained", 1'b0, 4'b1111);
      pop_cycle("no33", 4'b1111, 4'b0000, 0, 0, 0, 0);

      // Over-range request with two entries held
      push_one(32'h20);
      push_one(32'h21);
      check_flags("two", 1'b0, 4'b1100);
      pop_cycle("over", 4'b1111, 4'b0011, 32'h20, 32'h21, 0, 0);
      check_flags("over", 1'b0, 4'b1111);

      // Non-contiguous request is ignored entirely
      for (int i = 0; i < 3; i++) push_one(32'h30 + i);
      pop_cycle("gap", 4'b0010, 4'b0000, 0, 0, 0, 0);
      check_flags("gap", 1'b0, 4'b1000);
      pop_cycle("gap_all", 4'b1111, 4'b0111, 32'h30, 32'h31, 32'h32, 0);

      // Steady state at occupancy 5 with wrap-around
      for (int i = 0; i < 5; i++) push_one(32'h40 + i);
      for (int i = 0; i < 40; i++) begin
         push = 1'b1;
         push_data = 32'h45 + i;
         pop_cycle("steady", 4'b0001, 4'b0001, 32'h40 + i, 0, 0, 0);
         push = 1'b0;
         check_flags("steady", 1'b0, 4'b0000);
      end
      pop_cycle("st_drain", 4'b1111, 4'b1111, 32'h68, 32'h69, 32'h6A, 32'h6B);
      check_flags("st_drain", 1'b0, 4'b1110);
      pop_cycle("st_last", 4'b1111, 4'b0001, 32'h6C, 0, 0, 0);
      check_flags("st_last", 1'b0, 4'b1111);

      // Mid-operation reset discards contents
      for (int i = 0; i < 10; i++) push_one(32'h50 + i);
      check_flags("ten", 1'b0, 4'b0000);
      rst = 1'b1;
      set_pops(4'b1111);
      tick();
      rst = 1'b0;
      set_pops(4'b0000);
      check_flags("rst_mid", 1'b0, 4'b1111);
      check("rst_mid_valid", {60'd0, v3, v2, v1, v0}, 64'd0);
      push_one(32'h77);
      check_flags("after_rst", 1'b0, 4'b1110);
      pop_cycle("after_rst", 4'b1111, 4'b0001, 32'h77, 0, 0, 0);
      check_flags("after_rst_pop", 1'b0, 4'b1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_multi_pop.md
FIFO_MULTI_POP -- requirements
Module: fifo_multi_pop

Interface
REQ-001 Parameter W, default 32: data width in bits.
REQ-002 Parameter N, default 8: depth per bank, power of two; 4 banks, total capacity 4N.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 push  input  1  push request; push_data  input  W  push payload.
REQ-006 pop_k (k=0..3)  input  1  pop request for the (k+1)-th oldest entry.
REQ-007 pop_k_valid_r (k=0..3)  output  1  registered valid for slot k.
REQ-008 pop_k_data_r (k=0..3)  output  W  registered data for slot k.
REQ-009 full_r  output  1  registered; a push this cycle is dropped.
REQ-010 empty_r  output  4  registered; bit k set = fewer than k+1 entries held.

Function
REQ-011 Entries SHALL be stored round-robin over 4 banks; a one-hot push index SHALL select the write bank and rotate by 1 on each accepted push.
REQ-012 A one-hot pop index SHALL identify the oldest-entry bank; slot k SHALL read the bank at pop index rotated by k.
REQ-013 Accepted push = push & ~full_r.
REQ-014 Accepted pop_k = pop_k & ~empty_r[k] & accepted pop_(k-1); a non-contiguous or over-range request SHALL be truncated to the accepted prefix, with no error.
REQ-015 Pop index SHALL rotate by the popcount of accepted pops (0..4) in one cycle; each affected bank read pointer SHALL advance by 1.
REQ-016 pop_k_valid_r SHALL assert exactly one cycle after accepted pop_k; pop_k_data_r SHALL carry that entry, ordered oldest-first across slots 0..3.
REQ-017 pop_k_data_r is unspecified when pop_k_valid_r is low.
REQ-018 Same-cycle push and pops SHALL both take effect; a pushed entry SHALL NOT be poppable before the following cycle.
REQ-019 full_r and empty_r SHALL reflect post-update state each cycle (no false full/empty, no lag).
REQ-020 Bank pointers SHALL be log2(N)+1 bits with a wrap bit; full = wrap bits differ and indices equal; empty = pointers equal.

Reset
REQ-021 On rst: pointers 0, push/pop indices 4'b0001, full_r 0, empty_r 4'b1111, all pop_k_valid_r 0.
REQ-022 Storage and pop_k_data_r SHALL NOT be reset.
REQ-023 rst asserted mid-operation SHALL discard all contents; valids SHALL be 0 in the cycle after rst.

Configuration
REQ-024 Macro FIFO_MULTI_POP_CNT_EN defined: output cnt_r (width $clog2(4N)+1) SHALL give registered occupancy, reset 0, updated by +push -popcount.
REQ-025 Macro undefined: no cnt_r port and no counter logic; all other behaviour SHALL be identical.

Structure
REQ-026 Package fifo_multi_pop_pkg SHALL hold the bank count constant (4), its log2, and the pointer struct (wrap bit + index).
REQ-027 The one-hot rotation SHALL be the existing rotate sub-module, instantiated for push index (by 1) and pop index (by popcount); popcount SHALL reuse the existing popcnt.

Verification (W=32, N=8)
REQ-028 Push 0x10..0x13 on consecutive cycles, then pop_0..pop_3 together -> next cycle all valids 1, data 0x10,0x11,0x12,0x13 on slots 0..3; empty_r = 4'b1111.
REQ-029 Push 32 entries -> full_r=1 after the 32nd; 33rd push dropped; drain 4 per cycle -> 8 cycles, data in order, no 33rd value.
REQ-030 Hold 2 entries, request pop_0..pop_3 -> only slots 0,1 valid; empty_r = 4'b1111 afterwards.
REQ-031 Request pop_1 without pop_0 with 3 entries held -> no valids, occupancy unchanged.
REQ-032 Steady state at occupancy 5: push each cycle with pop_0 each cycle for 40 cycles -> wrap-around correct, data ordered, full_r stays 0, empty_r = 4'b0000.
REQ-033 Assert rst with 10 entries held -> next cycle empty_r=4'b1111, full_r=0, valids 0; a subsequent push-then-pop returns the new value only.
